// File: rtl/multdiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_sequencer_if
// Description : Bundle of the X-stage signals exchanged between the pipeline,
//               the multdiv core and the multdiv sequencer. The master modport
//               is the sequencer's view; the slave modport is the pipeline/core
//               side that drives instructions, operands and core responses.
// Revision    : 1.0 - initial release
// ============================================================================
interface multdiv_sequencer_if;
    // Pipeline side: instruction and post-bypass operands
    logic [31:0] DX_Latch_Instr;
    logic [31:0] operand_A;
    logic [31:0] operand_B;

    // Multdiv core response
    logic        md_resultRDY;
    logic        md_exception;
    logic [31:0] md_result;

    // Multdiv core launch
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;

    // Pipeline control and XM result
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [4:0]  result_rd;
    logic [31:0] result_data;
    logic        result_error;
    logic [31:0] result_rstatus;

    modport master (
        input  DX_Latch_Instr,
        input  operand_A,
        input  operand_B,
        input  md_resultRDY,
        input  md_exception,
        input  md_result,
        output md_ctrl_MULT,
        output md_ctrl_DIV,
        output md_operandA,
        output md_operandB,
        output stall,
        output busy,
        output result_valid,
        output result_rd,
        output result_data,
        output result_error,
        output result_rstatus
    );

    modport slave (
        output DX_Latch_Instr,
        output operand_A,
        output operand_B,
        output md_resultRDY,
        output md_exception,
        output md_result,
        input  md_ctrl_MULT,
        input  md_ctrl_DIV,
        input  md_operandA,
        input  md_operandB,
        input  stall,
        input  busy,
        input  result_valid,
        input  result_rd,
        input  result_data,
        input  result_error,
        input  result_rstatus
    );
endinterface
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_sequencer
// Description : X-stage controller for the iterative multiply/divide core.
//               Detects mul/div in DX, captures operands, pulses the core
//               start, stalls PC/FD/DX while the core runs and hands the
//               result (with error flag and rstatus) to the XM latch.
//               Optional feature macro: MULTDIV_WATCHDOG_EN - aborts a BUSY
//               wait after MAX_CYCLES cycles and reports an error result.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_sequencer #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input wire                  clock,
    input wire                  reset,
    multdiv_sequencer_if.master seq_if
);

    // Elaboration-time sanity check: the watchdog counter must reach the limit
    generate
        if ((1 << CNT_W) <= MAX_CYCLES) begin : g_cnt_w_check
            $error("multdiv_sequencer: CNT_W too narrow for MAX_CYCLES");
        end
    endgenerate

    localparam logic [4:0]  c_ALU_MUL     = 5'b00110;
    localparam logic [4:0]  c_ALU_DIV     = 5'b00111;
    localparam logic [31:0] c_RSTATUS_MUL = 32'd4;
    localparam logic [31:0] c_RSTATUS_DIV = 32'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state_q;
    logic        is_div_q;
    logic        md_ctrl_mult_q;
    logic        md_ctrl_div_q;
    logic [31:0] md_operand_a_q;
    logic [31:0] md_operand_b_q;
    logic        busy_q;
    logic        result_valid_q;
    logic [4:0]  result_rd_q;
    logic [31:0] result_data_q;
    logic        result_error_q;
    logic [31:0] result_rstatus_q;

`ifdef MULTDIV_WATCHDOG_EN
    localparam logic [CNT_W-1:0] c_WD_LIMIT = CNT_W'(MAX_CYCLES - 1);
    logic [CNT_W-1:0] wd_cnt_q;
`endif

    // R-type opcode with the mul or div ALU op in the DX latch
    logic w_is_rtype;
    logic w_detect;
    assign w_is_rtype = (seq_if.DX_Latch_Instr[31:27] == 5'd0);
    assign w_detect   = w_is_rtype &&
                        ((seq_if.DX_Latch_Instr[6:2] == c_ALU_MUL) ||
                         (seq_if.DX_Latch_Instr[6:2] == c_ALU_DIV));

    // Sequencer FSM with all registered outputs; reset aborts any operation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            is_div_q         <= 1'b0;
            md_ctrl_mult_q   <= 1'b0;
            md_ctrl_div_q    <= 1'b0;
            md_operand_a_q   <= 32'd0;
            md_operand_b_q   <= 32'd0;
            busy_q           <= 1'b0;
            result_valid_q   <= 1'b0;
            result_rd_q      <= 5'd0;
            result_data_q    <= 32'd0;
            result_error_q   <= 1'b0;
            result_rstatus_q <= 32'd0;
`ifdef MULTDIV_WATCHDOG_EN
            wd_cnt_q         <= '0;
`endif
        end else begin
            // Start pulses and the result strobe are single-cycle by default
            md_ctrl_mult_q <= 1'b0;
            md_ctrl_div_q  <= 1'b0;
            result_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (w_detect) begin
                        md_operand_a_q <= seq_if.operand_A;
                        md_operand_b_q <= seq_if.operand_B;
                        result_rd_q    <= seq_if.DX_Latch_Instr[26:22];
                        // mul and div ALU ops differ only in the low op bit
                        is_div_q       <= seq_if.DX_Latch_Instr[2];
                        md_ctrl_mult_q <= ~seq_if.DX_Latch_Instr[2];
                        md_ctrl_div_q  <= seq_if.DX_Latch_Instr[2];
                        busy_q         <= 1'b1;
                        state_q        <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    // Core cannot answer in its start cycle; md_resultRDY ignored
`ifdef MULTDIV_WATCHDOG_EN
                    wd_cnt_q <= '0;
`endif
                    state_q  <= S_BUSY;
                end

                S_BUSY: begin
                    if (seq_if.md_resultRDY) begin
                        result_valid_q   <= 1'b1;
                        result_error_q   <= seq_if.md_exception;
                        result_data_q    <= seq_if.md_exception ? 32'd0 : seq_if.md_result;
                        result_rstatus_q <= !seq_if.md_exception ? 32'd0 :
                                            (is_div_q ? c_RSTATUS_DIV : c_RSTATUS_MUL);
                        state_q          <= S_DONE;
                    end
`ifdef MULTDIV_WATCHDOG_EN
                    // A real result in the limit cycle takes priority above
                    else if (wd_cnt_q == c_WD_LIMIT) begin
                        result_valid_q   <= 1'b1;
                        result_error_q   <= 1'b1;
                        result_data_q    <= 32'd0;
                        result_rstatus_q <= is_div_q ? c_RSTATUS_DIV : c_RSTATUS_MUL;
                        state_q          <= S_DONE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end

                S_DONE: begin
                    // The DX instruction advances into XM this cycle
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so the detect cycle itself is frozen
    assign seq_if.stall = !reset &&
                          (((state_q == S_IDLE) && w_detect) ||
                           (state_q == S_LAUNCH) ||
                           (state_q == S_BUSY));

    assign seq_if.md_ctrl_MULT   = md_ctrl_mult_q;
    assign seq_if.md_ctrl_DIV    = md_ctrl_div_q;
    assign seq_if.md_operandA    = md_operand_a_q;
    assign seq_if.md_operandB    = md_operand_b_q;
    assign seq_if.busy           = busy_q;
    assign seq_if.result_valid   = result_valid_q;
    assign seq_if.result_rd      = result_rd_q;
    assign seq_if.result_data    = result_data_q;
    assign seq_if.result_error   = result_error_q;
    assign seq_if.result_rstatus = result_rstatus_q;

endmodule
`default_nettype wire

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Controls the iterative multiply/divide unit in the X stage of the five-stage pipeline. A `mul` or `div` in the DX latch is detected here. The block then captures the bypassed operands, starts the multdiv core, and stalls PC/FD/DX while the core runs. When the core finishes, it returns the result with error flag and rstatus code for the XM latch, so the pipeline freezes only for the multicycle operation.

## Interface
- `MAX_CYCLES`, 40: watchdog limit in BUSY cycles (used only with `MULTDIV_WATCHDOG_EN`).
- `CNT_W`, 6: watchdog counter width; must satisfy 2^CNT_W > MAX_CYCLES.

- `clock`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `DX_Latch_Instr`  in  32  instruction in DX.
- `operand_A`, `operand_B`  in  32 each  post-bypass ALU A/B inputs.
- `md_resultRDY`  in  1  multdiv done strobe.
- `md_exception`  in  1  multdiv exception, valid with `md_resultRDY`.
- `md_result`  in  32  multdiv result, valid with `md_resultRDY`.
- `md_ctrl_MULT`, `md_ctrl_DIV`  out  1 each  one-cycle start pulses.
- `md_operandA`, `md_operandB`  out  32 each  registered operands, held until DONE.
- `stall`  out  1  freeze PC, FD, DX; insert nop into XM.
- `busy`  out  1  state != IDLE.
- `result_valid`  out  1  one-cycle: load `result_*` into XM.
- `result_rd`  out  5  destination register of the sequenced instruction.
- `result_data`  out  32  product/quotient; 0 on error.
- `result_error`  out  1  to XM_ErrorFlag latch.
- `result_rstatus`  out  32  4 = mul error, 5 = div error, 0 otherwise.

## Operation
- Detect: `DX_Latch_Instr[31:27]==0`, with ALU op `[6:2]` equal to 00110 (mul) or 00111 (div).
- FSM states: IDLE, LAUNCH, BUSY, DONE.
  - IDLE: on detect, register `operand_A`/`operand_B`, rd `[26:22]` and kind (mul/div), then go to LAUNCH.
  - LAUNCH: assert the `md_ctrl_MULT` or `md_ctrl_DIV` matching the kind for exactly this cycle; `md_resultRDY` is ignored; go to BUSY.
  - BUSY: on `md_resultRDY`, capture `md_result` and `md_exception`, then go to DONE.
  - DONE: `result_valid=1`; go to IDLE.
- On exception: `result_data=0`, `result_error=1`, `result_rstatus` = 4 (mul) or 5 (div).
- `md_resultRDY` in IDLE or DONE is ignored.
- rd = 0 is sequenced normally; the register file discards the write.
- `stall` (combinational) = !reset && ((IDLE && detect) || LAUNCH || BUSY).
  - Deasserted in DONE, so the instruction in DX advances into XM with the result.
- A mul/div present in DX in the cycle after DONE is a new instruction and launches normally.

## Timing
- Reset (async) values:
  - state IDLE.
  - `md_ctrl_*`, `busy`, `result_valid`, `result_error` = 0.
  - `md_operand*`, `result_rd`, `result_data`, `result_rstatus` = 0.
  - `stall` forced to 0.
- Detect at cycle T:
  - `stall` high at T.
  - `md_ctrl_*` pulse at T+1.
  - `md_resultRDY` first seen at R ≥ T+2.
  - DONE at R+1 with `stall` low; IDLE at R+2.
- Total stall cycles = R−T+1.
- Reset mid-operation: the FSM aborts to IDLE immediately and no result is emitted. A late `md_resultRDY` from the aborted operation is ignored.
- Outputs other than `stall` are registered.

## Configuration
- `MULTDIV_WATCHDOG_EN` defined:
  - A CNT_W counter clears on entry to BUSY and increments each BUSY cycle.
  - If the counter reaches MAX_CYCLES−1 without `md_resultRDY`, go to DONE with `result_error=1`, `result_data=0` and rstatus 4 or 5.
  - If `md_resultRDY` arrives in the same cycle as the limit, the real result wins.
- Not defined: no counter; BUSY waits indefinitely for `md_resultRDY`.

## Test plan
- `mul $5,$1,$2` with A=3, B=7; core returns 21 sixteen cycles after the pulse (R=T+17) -> `stall` high T..T+17; DONE at T+18 with `result_data`=21, `result_rd`=5, `result_error`=0.
- `div $4,$1,$2` with B=0; core raises `md_exception` -> DONE with `result_error`=1, `result_rstatus`=5, `result_data`=0.
- `mul` immediately followed by `div` in DX -> second detect in the cycle after DONE; `md_ctrl_DIV` one cycle later; each instruction yields exactly one `result_valid`.
- Reset asserted in BUSY, then `md_resultRDY` pulsed after reset drops -> all outputs 0 at once; no `result_valid`; `stall` stays 0.
- Watchdog (`MULTDIV_WATCHDOG_EN`, MAX_CYCLES=40), `md_resultRDY` never asserted on a mul -> DONE after 40 BUSY cycles with `result_error`=1, `result_rstatus`=4.
- `add`, `addi` and nop (0x00000000) in DX -> `stall`=0, `busy`=0, no `md_ctrl_*` pulse.
